// File: rtl/busio_arbiter.sv
// Arbitrates one external 32-bit bus between the fetch port and the memory-stage port.
// Mem has fixed priority; formats store lanes and extends load data per access.
module busio_arbiter #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    output logic        mem_ready,
    output logic        mem_misaligned,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_strobe,
    output logic        ext_read,
    output logic        ext_write,
    input  logic [31:0] ext_read_data,
    input  logic        ext_ready
);

    typedef enum logic [1:0] {StIdle, StBusMem, StBusFetch, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  strobe_q, strobe_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic        owner_mem_q, owner_mem_d;
    logic        misaligned_q, misaligned_d;

    logic [1:0]  req_off;
    logic [31:0] req_wdata;
    logic [3:0]  req_strobe;
    logic        req_misaligned;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    logic in_mem, in_fetch, in_resp;

    // Store lane formatting from the live request, latched on grant.
    always_comb begin
        req_off        = mem_address[1:0];
        req_wdata      = mem_store_data;
        req_strobe     = 4'b1111;
        req_misaligned = 1'b0;
        case (mem_size)
            2'd0: begin
                req_wdata  = {4{mem_store_data[7:0]}};
                req_strobe = 4'b0001 << req_off;
            end
            2'd1: begin
                req_wdata      = {2{mem_store_data[15:0]}};
                req_strobe     = 4'b0011 << {req_off[1], 1'b0};
                req_misaligned = req_off[0];
            end
            default: begin
                req_wdata      = mem_store_data;
                req_strobe     = 4'b1111;
                req_misaligned = (req_off != 2'd0);
            end
        endcase
        req_misaligned = req_misaligned & ALIGN_CHECK;
    end

    // Load lane selection and extension from the latched request.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = ext_read_data[7:0];
            2'd1:    ld_byte = ext_read_data[15:8];
            2'd2:    ld_byte = ext_read_data[23:16];
            default: ld_byte = ext_read_data[31:24];
        endcase
        ld_half = addr_q[1] ? ext_read_data[31:16] : ext_read_data[15:0];
        case (size_q)
            2'd0:    ld_value = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_value = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_value = ext_read_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        strobe_d     = strobe_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        owner_mem_d  = owner_mem_q;
        misaligned_d = misaligned_q;
        case (state_q)
            StIdle: begin
                if (mem_load || mem_store) begin
                    addr_d       = mem_address;
                    wdata_d      = req_wdata;
                    strobe_d     = req_strobe;
                    size_d       = mem_size;
                    signed_d     = mem_signed;
                    write_d      = mem_store;
                    owner_mem_d  = 1'b1;
                    misaligned_d = req_misaligned;
                    rdata_d      = '0;
                    state_d      = req_misaligned ? StResp : StBusMem;
                end else begin
                    addr_d       = fetch_address;
                    write_d      = 1'b0;
                    owner_mem_d  = 1'b0;
                    misaligned_d = 1'b0;
                    state_d      = StBusFetch;
                end
            end
            StBusMem: begin
                if (ext_ready) begin
                    rdata_d = write_q ? 32'd0 : ld_value;
                    state_d = StResp;
                end
            end
            StBusFetch: begin
                if (ext_ready) begin
                    // A redirected fetch is dropped silently; the new address is fetched next.
                    if (fetch_address != addr_q) begin
                        state_d = StIdle;
                    end else begin
                        rdata_d = ext_read_data;
                        state_d = StResp;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            strobe_q     <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            owner_mem_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            strobe_q     <= strobe_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            owner_mem_q  <= owner_mem_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Outputs decode from state only, so reset drops the bus in the same cycle.
    always_comb begin
        in_mem         = (state_q == StBusMem);
        in_fetch       = (state_q == StBusFetch);
        in_resp        = (state_q == StResp);
        ext_read       = in_fetch | (in_mem & ~write_q);
        ext_write      = in_mem & write_q;
        ext_address    = (in_mem | in_fetch) ? {addr_q[31:2], 2'b00} : 32'd0;
        ext_write_data = ext_write ? wdata_q : 32'd0;
        ext_strobe     = ext_write ? strobe_q : 4'd0;
        fetch_ready    = in_resp & ~owner_mem_q;
        fetch_data     = fetch_ready ? rdata_q : 32'd0;
        mem_ready      = in_resp & owner_mem_q;
        mem_load_data  = mem_ready ? rdata_q : 32'd0;
        mem_misaligned = mem_ready & misaligned_q;
    end

endmodule

// File: tb/tb_busio_arbiter.sv
// Directed bench for busio_arbiter: stimulus pushes expected bus transfers and
// ready pulses into queues; a negedge monitor pops and compares them.
module tb_busio_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_address = 32'h100;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_store_data = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_signed = 1'b0;
    logic        mem_load = 1'b0;
    logic        mem_store = 1'b0;
    logic [31:0] mem_load_data;
    logic        mem_ready;
    logic        mem_misaligned;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_strobe;
    logic        ext_read;
    logic        ext_write;
    logic [31:0] ext_read_data = '0;
    logic        ext_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
        bit          mis;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    busio_arbiter #(.ALIGN_CHECK(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_address  (fetch_address),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .mem_address    (mem_address),
        .mem_store_data (mem_store_data),
        .mem_size       (mem_size),
        .mem_signed     (mem_signed),
        .mem_load       (mem_load),
        .mem_store      (mem_store),
        .mem_load_data  (mem_load_data),
        .mem_ready      (mem_ready),
        .mem_misaligned (mem_misaligned),
        .ext_address    (ext_address),
        .ext_write_data (ext_write_data),
        .ext_strobe     (ext_strobe),
        .ext_read       (ext_read),
        .ext_write      (ext_write),
        .ext_read_data  (ext_read_data),
        .ext_ready      (ext_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare bus completions and ready pulses against the queues.
    always @(negedge clk) begin
        bus_t b;
        rsp_t r;
        if (!reset) begin
            if (ext_ready && (ext_read || ext_write)) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", {30'd0, ext_read, ext_write}, 32'd0);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_write", 32'(ext_write), 32'(b.wr));
                    check("bus_read", 32'(ext_read), 32'(!b.wr));
                    check("bus_addr", ext_address, b.addr);
                    if (b.wr) begin
                        check("bus_strobe", 32'(ext_strobe), 32'(b.strb));
                        check("bus_wdata", ext_write_data, b.wd);
                    end
                end
            end
            if (fetch_ready || mem_ready) begin
                if (rsp_q.size() == 0) begin
                    check("ready_unexpected", {30'd0, fetch_ready, mem_ready}, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("ready_owner", {30'd0, fetch_ready, mem_ready},
                          r.is_mem ? 32'd1 : 32'd2);
                    check(r.is_mem ? "mem_load_data" : "fetch_data",
                          r.is_mem ? mem_load_data : fetch_data, r.data);
                    check("mem_misaligned", 32'(mem_misaligned), 32'(r.mis));
                end
            end
            if (!fetch_ready) check("fetch_data_idle", fetch_data, 32'd0);
            if (!mem_ready) check("mem_out_idle", mem_load_data | 32'(mem_misaligned), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_bus();
        int n = 0;
        while (!(ext_read || ext_write) && n < 20) begin
            tick();
            n++;
        end
        if (!(ext_read || ext_write)) check("bus_timeout", {30'd0, ext_read, ext_write}, 32'd2);
    endtask

    task automatic complete(input logic [31:0] rd, input int waits);
        repeat (waits) tick();
        ext_read_data = rd;
        ext_ready     = 1'b1;
        tick();
        ext_ready     = 1'b0;
        ext_read_data = '0;
    endtask

    task automatic release_mem();
        int n = 0;
        while (!mem_ready && n < 10) begin
            tick();
            n++;
        end
        if (!mem_ready) check("mem_ready_timeout", 32'(mem_ready), 32'd1);
        mem_load  = 1'b0;
        mem_store = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] rd);
        fetch_address = a;
        rsp_q.push_back('{1'b0, rd, 1'b0});
        wait_bus();
        bus_q.push_back('{1'b0, {a[31:2], 2'b00}, 4'd0, 32'd0});
        complete(rd, 0);
    endtask

    task automatic do_mem(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit exp_wr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd, input logic [31:0] rd,
                          input logic [31:0] exp_data, input int waits);
        mem_load       = ld;
        mem_store      = st;
        mem_size       = sz;
        mem_signed     = sg;
        mem_address    = a;
        mem_store_data = d;
        rsp_q.push_back('{1'b1, exp_data, 1'b0});
        wait_bus();
        bus_q.push_back('{exp_wr, {a[31:2], 2'b00}, exp_strb, exp_wd});
        complete(rd, waits);
        release_mem();
    endtask

    task automatic do_misaligned(input bit ld, input bit st, input logic [1:0] sz,
                                 input logic [31:0] a);
        int  n;
        bit  bus_seen = 1'b0;
        mem_load    = ld;
        mem_store   = st;
        mem_size    = sz;
        mem_address = a;
        rsp_q.push_back('{1'b1, 32'd0, 1'b1});
        for (n = 1; n <= 5; n++) begin
            tick();
            if (ext_read || ext_write) bus_seen = 1'b1;
            if (mem_ready) break;
        end
        check("misaligned_latency", 32'(n), 32'd2);
        check("misaligned_no_bus", 32'(bus_seen), 32'd0);
        mem_load  = 1'b0;
        mem_store = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ext_read", 32'(ext_read), 32'd0);
        check("rst_ext_write", 32'(ext_write), 32'd0);
        check("rst_ext_address", ext_address, 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        reset = 1'b0;

        // Plain fetch.
        do_fetch(32'h100, 32'h0000_0013);
        // Byte store raised during fetch RESP: mem wins the next IDLE, fetch follows.
        do_mem(1'b0, 1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00AB,
               1'b1, 4'b1000, 32'hABAB_ABAB, 32'd0, 32'd0, 0);
        do_fetch(32'h100, 32'h0000_0013);
        do_mem(1'b1, 1'b0, 2'd1, 1'b1, 32'h302, 32'd0,
               1'b0, 4'd0, 32'd0, 32'h8001_0000, 32'hFFFF_8001, 1);
        do_fetch(32'h104, 32'h0050_0093);
        do_mem(1'b1, 1'b0, 2'd1, 1'b0, 32'h302, 32'd0,
               1'b0, 4'd0, 32'd0, 32'h8001_0000, 32'h0000_8001, 0);
        do_fetch(32'h108, 32'h0010_0113);
        do_mem(1'b1, 1'b0, 2'd0, 1'b1, 32'h301, 32'd0,
               1'b0, 4'd0, 32'd0, 32'h0000_F000, 32'hFFFF_FFF0, 0);
        do_fetch(32'h10C, 32'h0020_0193);
        do_mem(1'b1, 1'b0, 2'd0, 1'b0, 32'h303, 32'd0,
               1'b0, 4'd0, 32'd0, 32'h7F00_0000, 32'h0000_007F, 2);
        do_fetch(32'h110, 32'h0030_0213);
        do_mem(1'b1, 1'b0, 2'd2, 1'b1, 32'h400, 32'd0,
               1'b0, 4'd0, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        do_fetch(32'h114, 32'h0040_0293);
        do_mem(1'b0, 1'b1, 2'd1, 1'b0, 32'h002, 32'h1234_5678,
               1'b1, 4'b1100, 32'h5678_5678, 32'd0, 32'd0, 0);
        do_fetch(32'h118, 32'h0050_0313);
        do_mem(1'b0, 1'b1, 2'd2, 1'b0, 32'h010, 32'hCAFE_F00D,
               1'b1, 4'b1111, 32'hCAFE_F00D, 32'd0, 32'd0, 0);
        do_fetch(32'h11C, 32'h0060_0393);
        // Load and store together are treated as a store.
        do_mem(1'b1, 1'b1, 2'd3, 1'b0, 32'h020, 32'h1122_3344,
               1'b1, 4'b1111, 32'h1122_3344, 32'd0, 32'd0, 0);

        // Fetch redirect while the bus stalls: data discarded, no fetch_ready.
        fetch_address = 32'h100;
        wait_bus();
        bus_q.push_back('{1'b0, 32'h100, 4'd0, 32'd0});
        tick();
        fetch_address = 32'h400;
        tick();
        tick();
        complete(32'h0000_0099, 0);
        check("squash_no_ready", 32'(fetch_ready), 32'd0);
        do_fetch(32'h400, 32'h0000_1234);

        do_misaligned(1'b1, 1'b0, 2'd2, 32'h1002);
        do_fetch(32'h404, 32'h0070_0413);
        do_misaligned(1'b0, 1'b1, 2'd1, 32'h0005);
        do_fetch(32'h408, 32'h0080_0493);

        // Reset in the middle of a mem bus cycle abandons the access.
        mem_load    = 1'b1;
        mem_size    = 2'd2;
        mem_address = 32'h40;
        wait_bus();
        check("rst_mid_pre_read", 32'(ext_read), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_ext_read", 32'(ext_read), 32'd0);
        check("rst_mid_ext_write", 32'(ext_write), 32'd0);
        check("rst_mid_ext_address", ext_address, 32'd0);
        check("rst_mid_mem_ready", 32'(mem_ready), 32'd0);
        mem_load = 1'b0;
        tick();
        reset = 1'b0;
        do_fetch(32'h100, 32'h0000_0055);

        repeat (3) tick();
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
